// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port SRAM between instruction fetch and load/store
// One access in flight at a time: grant in IDLE, strobe in ISSUE, wait out the read latency, pulse valid in RESP.
module mem_port_arbiter #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = 1,
   parameter int LS_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_in,
   input  logic [ADDR_W-1:0] if_addr_in,
   output logic              if_valid_out,
   output logic [DATA_W-1:0] if_data_out,
   input  logic              ls_req_in,
   input  logic              ls_we_in,
   input  logic [ADDR_W-1:0] ls_addr_in,
   input  logic [DATA_W-1:0] ls_wdata_in,
   output logic              ls_valid_out,
   output logic [DATA_W-1:0] ls_rdata_out,
   output logic              mem_en_out,
   output logic              mem_we_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [DATA_W-1:0] mem_wdata_out,
   input  logic [DATA_W-1:0] mem_rdata_in,
   output logic              busy_out
);

   localparam logic [DATA_W-1:0] IF_NOP = DATA_W'(16'hBF00);
   localparam logic [2:0]        LAT_M1 = 3'(MEM_LATENCY - 1);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be in 1..7");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       grant_vld;
   logic       grant_ls;
   logic       cur_ls;
   logic       cur_we;
   logic       last_ls;
   logic [2:0] lat_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // On a tie the port that was not served last wins, unless LS is configured to always win.
   always_comb begin
      state_nxt = state;
      grant_vld = 1'b0;
      grant_ls  = 1'b0;
      case (state)
         S_IDLE: begin
            if (if_req_in && ls_req_in) begin
               grant_vld = 1'b1;
               grant_ls  = (LS_PRIORITY != 0) || !last_ls;
            end else if (if_req_in) begin
               grant_vld = 1'b1;
               grant_ls  = 1'b0;
            end else if (ls_req_in) begin
               grant_vld = 1'b1;
               grant_ls  = 1'b1;
            end
            if (grant_vld) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: state_nxt = (cur_ls && cur_we) ? S_RESP : S_WAIT;
         S_WAIT:  state_nxt = (lat_cnt == 3'd0) ? S_RESP : S_WAIT;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_valid_out  <= 1'b0;
         if_data_out   <= IF_NOP;
         ls_valid_out  <= 1'b0;
         ls_rdata_out  <= '0;
         mem_en_out    <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         busy_out      <= 1'b0;
         cur_ls        <= 1'b0;
         cur_we        <= 1'b0;
         last_ls       <= 1'b1;
         lat_cnt       <= 3'd0;
      end else begin
         if_valid_out <= 1'b0;
         ls_valid_out <= 1'b0;
         mem_en_out   <= 1'b0;
         mem_we_out   <= 1'b0;
         busy_out     <= (state_nxt != S_IDLE);
         case (state)
            S_IDLE: begin
               // The memory bus registers double as the latched request for the rest of the access.
               if (grant_vld) begin
                  cur_ls        <= grant_ls;
                  cur_we        <= grant_ls && ls_we_in;
                  mem_en_out    <= 1'b1;
                  mem_we_out    <= grant_ls && ls_we_in;
                  mem_addr_out  <= grant_ls ? ls_addr_in : if_addr_in;
                  mem_wdata_out <= grant_ls ? ls_wdata_in : '0;
               end
            end
            S_ISSUE: begin
               if (cur_ls && cur_we) begin
                  ls_valid_out <= 1'b1;
               end else begin
                  lat_cnt <= LAT_M1;
               end
            end
            S_WAIT: begin
               if (lat_cnt == 3'd0) begin
                  if (cur_ls) begin
                     ls_rdata_out <= mem_rdata_in;
                     ls_valid_out <= 1'b1;
                  end else begin
                     if_data_out  <= mem_rdata_in;
                     if_valid_out <= 1'b1;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end
            S_RESP: begin
               last_ls <= cur_ls;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector and sequence bench for mem_port_arbiter
// Three instances: [0] latency 1 round-robin, [1] latency 3 round-robin, [2] latency 1 LS priority.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [11:0] if_addr;
   logic        ls_req;
   logic        ls_we;
   logic [11:0] ls_addr;
   logic [15:0] ls_wdata;

   logic [2:0]  if_valid, ls_valid, mem_en, mem_we, busy;
   logic [15:0] if_data   [3];
   logic [15:0] ls_rdata  [3];
   logic [11:0] mem_addr  [3];
   logic [15:0] mem_wdata [3];
   logic [15:0] mem_rdata [3];

   logic [15:0] mem_tbl [4096];
   logic [15:0] pipe [3][7];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LATENCY(1), .LS_PRIORITY(0)) u_dut (
      .clk(clk), .reset(reset),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_valid_out(if_valid[0]), .if_data_out(if_data[0]),
      .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
      .ls_valid_out(ls_valid[0]), .ls_rdata_out(ls_rdata[0]),
      .mem_en_out(mem_en[0]), .mem_we_out(mem_we[0]), .mem_addr_out(mem_addr[0]),
      .mem_wdata_out(mem_wdata[0]), .mem_rdata_in(mem_rdata[0]), .busy_out(busy[0]));

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LATENCY(3), .LS_PRIORITY(0)) u_dut_l3 (
      .clk(clk), .reset(reset),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_valid_out(if_valid[1]), .if_data_out(if_data[1]),
      .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
      .ls_valid_out(ls_valid[1]), .ls_rdata_out(ls_rdata[1]),
      .mem_en_out(mem_en[1]), .mem_we_out(mem_we[1]), .mem_addr_out(mem_addr[1]),
      .mem_wdata_out(mem_wdata[1]), .mem_rdata_in(mem_rdata[1]), .busy_out(busy[1]));

   mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LATENCY(1), .LS_PRIORITY(1)) u_dut_p1 (
      .clk(clk), .reset(reset),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_valid_out(if_valid[2]), .if_data_out(if_data[2]),
      .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
      .ls_valid_out(ls_valid[2]), .ls_rdata_out(ls_rdata[2]),
      .mem_en_out(mem_en[2]), .mem_we_out(mem_we[2]), .mem_addr_out(mem_addr[2]),
      .mem_wdata_out(mem_wdata[2]), .mem_rdata_in(mem_rdata[2]), .busy_out(busy[2]));

   // Memory model: data appears L cycles after the strobe; garbage at any other time.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         pipe[d][0] <= mem_en[d] ? mem_tbl[mem_addr[d]] : 16'hDEAD;
         for (int s = 1; s < 7; s++) pipe[d][s] <= pipe[d][s-1];
      end
   end
   assign mem_rdata[0] = pipe[0][0];
   assign mem_rdata[1] = pipe[1][2];
   assign mem_rdata[2] = pipe[2][0];

   typedef struct {
      logic        is_ls;
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] memval;
      int          lat;
      logic [15:0] exp_if;
      logic [15:0] exp_ls;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      if_req = 1'b0;
      ls_req = 1'b0;
      ls_we  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      mem_tbl[v.addr] = v.memval;
      if (v.is_ls) begin
         ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      for (int n = 1; n <= v.lat; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("issue_mem_en", mem_en[0], 1);
            chk("issue_mem_we", mem_we[0], v.we);
            chk("issue_mem_addr", mem_addr[0], v.addr);
            if (v.we) chk("issue_mem_wdata", mem_wdata[0], v.wdata);
            // Scramble the request fields; the latched access must be unaffected.
            if_addr  = ~v.addr;
            ls_addr  = ~v.addr;
            ls_wdata = ~v.wdata;
            ls_we    = ~v.we;
         end else begin
            chk("mem_en_single", mem_en[0], 0);
         end
         chk("if_valid", if_valid[0], (!v.is_ls) && (n == v.lat));
         chk("ls_valid", ls_valid[0], v.is_ls && (n == v.lat));
      end
      chk("if_data", if_data[0], v.exp_if);
      chk("ls_rdata", ls_rdata[0], v.exp_ls);
      if_req = 1'b0;
      ls_req = 1'b0;
      ls_we  = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy[0], 0);
      chk("idle_if_valid", if_valid[0], 0);
      chk("idle_ls_valid", ls_valid[0], 0);
   endtask

   initial begin
      int          g0, gp, found;
      logic [11:0] a0 [4];
      logic [11:0] ap [4];
      logic [11:0] ga;

      vecs[0] = '{1'b0, 1'b0, 12'h004, 16'h0000, 16'h2001, 3, 16'h2001, 16'h0000};
      vecs[1] = '{1'b1, 1'b1, 12'h010, 16'hBEEF, 16'h0000, 2, 16'h2001, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 12'h0FF, 16'h0000, 16'h1234, 3, 16'h2001, 16'h1234};
      vecs[3] = '{1'b0, 1'b0, 12'hFFF, 16'h0000, 16'hA5A5, 3, 16'hA5A5, 16'h1234};
      vecs[4] = '{1'b1, 1'b1, 12'h000, 16'h5A5A, 16'h0000, 2, 16'hA5A5, 16'h1234};
      vecs[5] = '{1'b1, 1'b0, 12'h010, 16'h0000, 16'h5678, 3, 16'hA5A5, 16'h5678};

      for (int i = 0; i < 4096; i++) mem_tbl[i] = 16'(i);
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      do_reset();

      chk("rst_busy", busy[0], 0);
      chk("rst_mem_en", mem_en[0], 0);
      chk("rst_mem_we", mem_we[0], 0);
      chk("rst_mem_addr", mem_addr[0], 0);
      chk("rst_if_valid", if_valid[0], 0);
      chk("rst_ls_valid", ls_valid[0], 0);
      chk("rst_if_data", if_data[0], 16'hBF00);
      chk("rst_ls_rdata", ls_rdata[0], 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Both requests held: round-robin alternates starting with IF; LS priority starves IF.
      do_reset();
      if_req = 1'b1; if_addr = 12'h100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h200;
      g0 = 0; gp = 0;
      for (int c = 0; c < 40 && (g0 < 4 || gp < 4); c++) begin
         @(negedge clk);
         if (mem_en[0] && g0 < 4) begin a0[g0] = mem_addr[0]; g0++; end
         if (mem_en[2] && gp < 4) begin ap[gp] = mem_addr[2]; gp++; end
      end
      chk("rr_grant_count", g0, 4);
      chk("pri_grant_count", gp, 4);
      for (int i = 0; i < g0; i++) chk("rr_grant_order", a0[i], (i % 2 == 0) ? 12'h100 : 12'h200);
      for (int i = 0; i < gp; i++) chk("pri_grant_ls", ap[i], 12'h200);
      ls_req = 1'b0;
      found = 0; ga = '0;
      for (int c = 0; c < 20 && found == 0; c++) begin
         @(negedge clk);
         if (mem_en[2]) begin found = 1; ga = mem_addr[2]; end
      end
      chk("pri_if_after_ls_drop_seen", found, 1);
      chk("pri_if_after_ls_drop_addr", ga, 12'h100);
      if_req = 1'b0;

      // Latency 3 LS read.
      do_reset();
      mem_tbl[12'h0FF] = 16'h1234;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 12'h0FF;
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         chk("l3_ls_valid", ls_valid[1], n == 5);
         chk("l3_if_valid", if_valid[1], 0);
      end
      chk("l3_ls_rdata", ls_rdata[1], 16'h1234);
      chk("l3_if_data", if_data[1], 16'hBF00);
      ls_req = 1'b0;
      @(negedge clk);
      chk("l3_ls_valid_end", ls_valid[1], 0);

      // Reset while in WAIT.
      do_reset();
      mem_tbl[12'h004] = 16'h2001;
      if_req = 1'b1; if_addr = 12'h004;
      repeat (2) @(negedge clk);
      chk("wait_busy_before_reset", busy[1], 1);
      reset = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("rstw_busy_l3", busy[1], 0);
      chk("rstw_busy_l1", busy[0], 0);
      chk("rstw_if_data_l3", if_data[1], 16'hBF00);
      chk("rstw_if_data_l1", if_data[0], 16'hBF00);
      chk("rstw_mem_en_l3", mem_en[1], 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rstw_no_if_valid_l3", if_valid[1], 0);
         chk("rstw_no_if_valid_l1", if_valid[0], 0);
         chk("rstw_no_mem_en_l3", mem_en[1], 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
